hit_receiver: RTL and testbench
===============================

Name: hit_receiver

Overview:
- Defender-side responder to player_attack.
- Each frame it rebuilds the attacker's active hitbox from the attacker position, facing and attack type, then tests it against the defender hurtbox.
- On a valid hit it applies damage, hit-stun, an invulnerability window and KO.
- One instance per player, clocked on the pixel clock with the frame-tick enable. It feeds player_move (move_enable) and the HUD/renderer.

Parameters:
- BOX_W, 60, hurtbox width in pixels (player box).
- BOX_H, 60, hurtbox height in pixels.
- ATK1_W, 30, type-1 hitbox width.
- ATK1_H, 60, type-1 hitbox height.
- ATK2_W, 60, type-2 hitbox width.
- ATK2_H, 60, type-2 hitbox height.
- DMG1, 10, type-1 damage.
- DMG2, 20, type-2 damage.
- CHIP_DMG, 2, damage taken while blocking.
- HEALTH_MAX, 100, health after reset.
- HP_W, 7, health width.
- HITSTUN_FRAMES, 20, stun duration in frames.
- INVULN_FRAMES, 30, post-stun invulnerability duration in frames.

Ports:
- clk  in  1  pixel clock (25 MHz).
- reset  in  1  synchronous, active-high.
- SCEN  in  1  frame tick, one clk wide. All state advances only on SCEN.
- enable  in  1  round active. When low, hits are ignored and counters hold.
- atk_pos_x  in  10  attacker box left x.
- atk_pos_y  in  10  attacker box top y.
- atk_facing_right  in  1  attacker facing.
- attack_active  in  1  attacker's attack_active.
- attack_type  in  2  1 = light, 2 = heavy, 0/3 = none.
- def_pos_x  in  10  defender box left x.
- def_pos_y  in  10  defender box top y.
- def_block  in  1  defender block held.
- health  out  HP_W  current health.
- hit_pulse  out  1  one-clk pulse when an unblocked hit lands.
- block_pulse  out  1  one-clk pulse when a blocked hit lands.
- hit_stun  out  1  high in STUN; drive to player_move as an inverted move_enable.
- invuln  out  1  high in INVULN.
- knockback_right  out  1  latched knockback direction; equals atk_facing_right at the hit.
- ko  out  1  high in KO.

Behaviour:
- Reset values:
  - health = HEALTH_MAX.
  - hit_pulse, block_pulse, hit_stun, invuln, ko = 0; knockback_right = 0.
  - State ALIVE, counters 0, consumed = 0.
  - Reset has priority over SCEN.
- Hitbox geometry (all arithmetic 11-bit unsigned, edges half-open [l, r)):
  - Size is ATK1_W/ATK1_H for type 1 and ATK2_W/ATK2_H for type 2. Types 0/3 produce no hitbox.
  - Facing right: l = atk_pos_x + BOX_W, r = l + W.
  - Facing left: r = atk_pos_x, l = max(atk_pos_x − W, 0), computed without wrap.
  - Vertical extent: [atk_pos_y, atk_pos_y + H).
  - Hurtbox: [def_pos_x, def_pos_x + BOX_W) × [def_pos_y, def_pos_y + BOX_H).
  - Overlap = (hl < dr) && (dl < hr) && (ht < db) && (dt < hb). Edges that only touch do not overlap.
- Qualified hit on a SCEN cycle: enable && attack_active && type ∈ {1,2} && overlap && !consumed && state == ALIVE.
- consumed flag (one hit per attack):
  - Set on any qualified hit.
  - Cleared on a SCEN where attack_active == 0.
  - If both conditions occur on the same SCEN, clear wins; set cannot happen then anyway.
- State machine, evaluated on SCEN only:
  - ALIVE, qualified hit with def_block = 0:
    - health ← max(health − DMG, 0); hit_pulse; knockback_right latched.
    - Go to KO if the new health is 0, else STUN with stun_cnt = HITSTUN_FRAMES.
  - ALIVE, qualified hit with def_block = 1:
    - health ← max(health − CHIP_DMG, 1); chip damage never KOs.
    - block_pulse; state stays ALIVE; no stun.
  - STUN: stun_cnt decrements each SCEN. On the SCEN where stun_cnt == 1, go to INVULN with inv_cnt = INVULN_FRAMES.
  - INVULN: hits are ignored and consumed is not set. inv_cnt decrements; at inv_cnt == 1, go to ALIVE.
  - KO: terminal until reset. Everything is ignored; health holds at 0.
- Latency:
  - Outputs are registered. Values reflect the SCEN decision on clk N+1.
  - Pulses are exactly one clk wide, on clk N+1.
  - hit_stun is high for exactly HITSTUN_FRAMES SCENs.
- enable low: counters and state freeze; no hits are evaluated; consumed still clears.
- Reset mid-STUN or mid-KO returns fully to reset values on the next clk.

Decomposition:
- Shared package fighter_pkg holds:
  - Box/attack dimension constants (BOX_W, BOX_H, ATK*_W/H) and damage constants, shared with the renderer and player_attack.
  - State encoding: ALIVE = 0, STUN = 1, INVULN = 2, KO = 3.
  - Attack-type encoding: NONE = 0, LIGHT = 1, HEAVY = 2.
- One sub-module, hitbox_overlap: purely combinational geometry plus overlap test. The renderer reuses it for the attack-box overlay.

Test Plan:
- Attacker at (200,300) facing right, type 1, defender at (265,300), attack_active held for 5 SCENs → one hit_pulse, health 90, hit_stun high for 20 SCENs, then invuln for 30, then ALIVE.
- Same setup with defender at (290,300) (left edge equals hitbox right edge of 290) → no hit; health stays 100.
- Attacker at (10,300) facing left, type 2, defender at (0,300) → hitbox [0,10) with no wrap; hit lands, health 80, knockback_right = 0.
- def_block = 1, type 2 hits applied one after another with attack_active dropping between them → health goes 98, 96, …, floors at 1; never KO; block_pulse on each; no stun.
- Five type-2 hits, each in a new ALIVE window → health 20, 0 at the fifth; ko = 1; further hits and SCEN ignored; reset → health 100, ko = 0.
- A hit lands on SCEN N, then the attack ends and a new attack starts while in STUN/INVULN → ignored, no pulse. Assert reset on the same clk as SCEN → reset values win.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared fighter constants, state/attack encodings, the debug view of the
// hit receiver, and a saturating health subtract.
package fighter_pkg;

  // Box and attack geometry in pixels, shared with the renderer and player_attack.
  localparam int BOX_W  = 60;
  localparam int BOX_H  = 60;
  localparam int ATK1_W = 30;
  localparam int ATK1_H = 60;
  localparam int ATK2_W = 60;
  localparam int ATK2_H = 60;

  // Damage and health.
  localparam int DMG1       = 10;
  localparam int DMG2       = 20;
  localparam int CHIP_DMG   = 2;
  localparam int HEALTH_MAX = 100;
  localparam int HP_W       = 7;

  // Frame-count durations.
  localparam int HITSTUN_FRAMES = 20;
  localparam int INVULN_FRAMES  = 30;
  localparam int CNT_W          = 5;

  // Coordinate widths: screen positions are 10 bits, box math is 11 bits.
  localparam int COORD_W = 10;
  localparam int GEO_W   = 11;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_STUN   = 2'd1,
    ST_INVULN = 2'd2,
    ST_KO     = 2'd3
  } fighter_state_e;

  typedef enum logic [1:0] {
    ATK_NONE  = 2'd0,
    ATK_LIGHT = 2'd1,
    ATK_HEAVY = 2'd2
  } attack_type_e;

  // Internal view of the receiver, exported for checkers and the attack-box overlay.
  typedef struct packed {
    fighter_state_e   state;
    logic [CNT_W-1:0] stun_cnt;
    logic [CNT_W-1:0] inv_cnt;
    logic             consumed;
    logic             box_valid;
    logic [GEO_W-1:0] hit_l;
    logic [GEO_W-1:0] hit_r;
    logic [GEO_W-1:0] hit_t;
    logic [GEO_W-1:0] hit_b;
    logic             overlap;
  } hit_dbg_t;

  // h - d, but never below floor_v.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] h,
                                               input logic [HP_W-1:0] d,
                                               input logic [HP_W-1:0] floor_v);
    if (h > d + floor_v) return h - d;
    else return floor_v;
  endfunction

endpackage

// File: rtl/hit_receiver_if.sv
// Signal bundle between the attacker/defender logic and the hit receiver.
// There is no valid/ready handshake: SCEN is a one-clk frame strobe that
// qualifies every input on that clk; outputs are registered and valid on
// every clk, changing only on the clk after a SCEN (or after reset).
interface hit_receiver_if;
  import fighter_pkg::*;

  logic               SCEN;
  logic               enable;
  logic [COORD_W-1:0] atk_pos_x;
  logic [COORD_W-1:0] atk_pos_y;
  logic               atk_facing_right;
  logic               attack_active;
  logic [1:0]         attack_type;
  logic [COORD_W-1:0] def_pos_x;
  logic [COORD_W-1:0] def_pos_y;
  logic               def_block;

  logic [HP_W-1:0]    health;
  logic               hit_pulse;
  logic               block_pulse;
  logic               hit_stun;
  logic               invuln;
  logic               knockback_right;
  logic               ko;
  hit_dbg_t           dbg;

  modport master (
    output SCEN, enable, atk_pos_x, atk_pos_y, atk_facing_right,
           attack_active, attack_type, def_pos_x, def_pos_y, def_block,
    input  health, hit_pulse, block_pulse, hit_stun, invuln,
           knockback_right, ko, dbg
  );

  modport slave (
    input  SCEN, enable, atk_pos_x, atk_pos_y, atk_facing_right,
           attack_active, attack_type, def_pos_x, def_pos_y, def_block,
    output health, hit_pulse, block_pulse, hit_stun, invuln,
           knockback_right, ko, dbg
  );
endinterface

// File: rtl/hitbox_overlap.sv
// Builds the attacker hitbox from position/facing/type and tests it against
// the defender hurtbox. Purely combinational; edges are half-open [l, r).
module hitbox_overlap
  import fighter_pkg::*;
(
  input  logic [COORD_W-1:0] atk_pos_x,
  input  logic [COORD_W-1:0] atk_pos_y,
  input  logic               atk_facing_right,
  input  logic [1:0]         attack_type,
  input  logic [COORD_W-1:0] def_pos_x,
  input  logic [COORD_W-1:0] def_pos_y,
  output logic               box_valid,
  output logic [GEO_W-1:0]   hit_l,
  output logic [GEO_W-1:0]   hit_r,
  output logic [GEO_W-1:0]   hit_t,
  output logic [GEO_W-1:0]   hit_b,
  output logic               overlap
);

  logic [GEO_W-1:0] w, h, ax, ay, dl, dr, dt, db;

  // Hitbox size by type, then edges; facing left clamps at x = 0 instead of wrapping.
  always_comb begin
    w         = '0;
    h         = '0;
    box_valid = 1'b0;
    case (attack_type)
      ATK_LIGHT: begin w = GEO_W'(ATK1_W); h = GEO_W'(ATK1_H); box_valid = 1'b1; end
      ATK_HEAVY: begin w = GEO_W'(ATK2_W); h = GEO_W'(ATK2_H); box_valid = 1'b1; end
      default:   begin w = '0; h = '0; box_valid = 1'b0; end
    endcase

    ax = {1'b0, atk_pos_x};
    ay = {1'b0, atk_pos_y};
    if (atk_facing_right) begin
      hit_l = ax + GEO_W'(BOX_W);
      hit_r = hit_l + w;
    end else begin
      hit_r = ax;
      hit_l = (ax >= w) ? ax - w : '0;
    end
    hit_t = ay;
    hit_b = ay + h;

    dl = {1'b0, def_pos_x};
    dr = dl + GEO_W'(BOX_W);
    dt = {1'b0, def_pos_y};
    db = dt + GEO_W'(BOX_H);

    overlap = box_valid && (hit_l < dr) && (dl < hit_r) && (hit_t < db) && (dt < hit_b);
  end

endmodule

// File: rtl/hit_receiver.sv
// Defender-side hit handling: damage, chip damage on block, hit-stun,
// post-stun invulnerability and KO. All state advances on SCEN only.
module hit_receiver
  import fighter_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  hit_receiver_if.slave  bus
);

  fighter_state_e   state_q, state_d;
  logic [HP_W-1:0]  health_q, health_d;
  logic [CNT_W-1:0] stun_q, stun_d;
  logic [CNT_W-1:0] inv_q, inv_d;
  logic             consumed_q, consumed_d;
  logic             kb_q, kb_d;
  logic             hit_pulse_q, hit_pulse_d;
  logic             block_pulse_q, block_pulse_d;

  logic             box_valid, overlap, qualified;
  logic [GEO_W-1:0] hit_l, hit_r, hit_t, hit_b;
  logic [HP_W-1:0]  dmg;

  hitbox_overlap u_geom (
    .atk_pos_x        (bus.atk_pos_x),
    .atk_pos_y        (bus.atk_pos_y),
    .atk_facing_right (bus.atk_facing_right),
    .attack_type      (bus.attack_type),
    .def_pos_x        (bus.def_pos_x),
    .def_pos_y        (bus.def_pos_y),
    .box_valid        (box_valid),
    .hit_l            (hit_l),
    .hit_r            (hit_r),
    .hit_t            (hit_t),
    .hit_b            (hit_b),
    .overlap          (overlap)
  );

  // Only one hit per attack, and only while ALIVE; overlap already excludes types 0/3.
  assign qualified = bus.SCEN && bus.enable && bus.attack_active && overlap &&
                     !consumed_q && (state_q == ST_ALIVE);
  assign dmg = (bus.attack_type == ATK_HEAVY) ? HP_W'(DMG2) : HP_W'(DMG1);

  // State register; reset wins over SCEN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ALIVE;
      health_q      <= HP_W'(HEALTH_MAX);
      stun_q        <= '0;
      inv_q         <= '0;
      consumed_q    <= 1'b0;
      kb_q          <= 1'b0;
      hit_pulse_q   <= 1'b0;
      block_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      health_q      <= health_d;
      stun_q        <= stun_d;
      inv_q         <= inv_d;
      consumed_q    <= consumed_d;
      kb_q          <= kb_d;
      hit_pulse_q   <= hit_pulse_d;
      block_pulse_q <= block_pulse_d;
    end
  end

  // Next-state: consumed clears even when disabled; everything else freezes unless SCEN && enable.
  always_comb begin
    state_d       = state_q;
    health_d      = health_q;
    stun_d        = stun_q;
    inv_d         = inv_q;
    consumed_d    = consumed_q;
    kb_d          = kb_q;
    hit_pulse_d   = 1'b0;
    block_pulse_d = 1'b0;

    if (bus.SCEN && !bus.attack_active) consumed_d = 1'b0;
    else if (qualified)                 consumed_d = 1'b1;

    if (bus.SCEN && bus.enable) begin
      case (state_q)
        ST_ALIVE: begin
          if (qualified) begin
            if (bus.def_block) begin
              health_d      = sat_sub(health_q, HP_W'(CHIP_DMG), HP_W'(1));
              block_pulse_d = 1'b1;
            end else begin
              health_d    = sat_sub(health_q, dmg, '0);
              hit_pulse_d = 1'b1;
              kb_d        = bus.atk_facing_right;
              if (health_d == '0) begin
                state_d = ST_KO;
              end else begin
                state_d = ST_STUN;
                stun_d  = CNT_W'(HITSTUN_FRAMES);
              end
            end
          end
        end
        ST_STUN: begin
          if (stun_q == CNT_W'(1)) begin
            state_d = ST_INVULN;
            stun_d  = '0;
            inv_d   = CNT_W'(INVULN_FRAMES);
          end else begin
            stun_d = stun_q - CNT_W'(1);
          end
        end
        ST_INVULN: begin
          if (inv_q == CNT_W'(1)) begin
            state_d = ST_ALIVE;
            inv_d   = '0;
          end else begin
            inv_d = inv_q - CNT_W'(1);
          end
        end
        ST_KO: begin
          state_d = ST_KO;
        end
      endcase
    end
  end

  assign bus.health          = health_q;
  assign bus.hit_pulse       = hit_pulse_q;
  assign bus.block_pulse     = block_pulse_q;
  assign bus.hit_stun        = (state_q == ST_STUN);
  assign bus.invuln          = (state_q == ST_INVULN);
  assign bus.ko              = (state_q == ST_KO);
  assign bus.knockback_right = kb_q;
  assign bus.dbg = '{state: state_q, stun_cnt: stun_q, inv_cnt: inv_q,
                     consumed: consumed_q, box_valid: box_valid,
                     hit_l: hit_l, hit_r: hit_r, hit_t: hit_t, hit_b: hit_b,
                     overlap: overlap};

endmodule

// File: tb/tb_hit_receiver.sv
// Bench for hit_receiver: geometry vector table plus multi-frame sequences,
// checked through an expected-value queue.
module tb_hit_receiver;
  import fighter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  hit_receiver_if bus();
  hit_receiver dut (.clk(clk), .reset(reset), .bus(bus));

  // ---------------- scoreboard ----------------
  // packed expectation: {ko, invuln, hit_stun, block_pulse, hit_pulse, knockback_right, health[6:0]}
  logic [12:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit last_pulse = 0;

  // reference model state
  int m_state, m_health, m_stun, m_inv, m_kb;
  bit m_consumed;

  typedef struct {
    int ax; int ay; bit fr; int ty; int dx; int dy; bit blk; bit en;
    bit e_hit; bit e_blk; bit e_kb; int e_hp;
  } vec_t;
  vec_t tbl[16];

  function automatic logic [12:0] pack_exp(bit ko, bit inv, bit stun, bit bp, bit hp, bit kb, int health);
    logic [6:0] h;
    h = 7'(health);
    return {ko, inv, stun, bp, hp, kb, h};
  endfunction

  function automatic logic [12:0] observed();
    return {bus.ko, bus.invuln, bus.hit_stun, bus.block_pulse, bus.hit_pulse,
            bus.knockback_right, bus.health};
  endfunction

  task automatic check(input string name);
    logic [12:0] e, o;
    n_checks++;
    o = observed();
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: no expected value queued, got %b", name, o);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        n_errors++;
        $display("FAIL %s: got {ko,inv,stun,blk,hit,kb}=%b health=%0d, expected %b health=%0d",
                 name, o[12:7], o[6:0], e[12:7], e[6:0]);
      end
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // ---------------- model ----------------
  function automatic bit model_overlap(int ax, int ay, bit fr, int ty, int dx, int dy);
    int w, h, l, r;
    if (ty == 1) begin w = 30; h = 60; end
    else if (ty == 2) begin w = 60; h = 60; end
    else return 0;
    if (fr) begin l = ax + 60; r = l + w; end
    else begin r = ax; l = ax - w; if (l < 0) l = 0; end
    return (l < dx + 60) && (dx < r) && (ay < dy + 60) && (dy < ay + h);
  endfunction

  task automatic model_reset();
    m_state = 0; m_health = 100; m_stun = 0; m_inv = 0; m_kb = 0; m_consumed = 0;
    last_pulse = 0;
  endtask

  function automatic logic [12:0] model_pack(bit bp, bit hp);
    return pack_exp(m_state == 3, m_state == 2, m_state == 1, bp, hp, m_kb[0], m_health);
  endfunction

  task automatic model_step();
    bit q, ov, hp, bp;
    int d;
    hp = 0; bp = 0;
    ov = model_overlap(int'(bus.atk_pos_x), int'(bus.atk_pos_y), bus.atk_facing_right,
                       int'(bus.attack_type), int'(bus.def_pos_x), int'(bus.def_pos_y));
    q = bus.enable && bus.attack_active && ov && !m_consumed && (m_state == 0);
    if (!bus.attack_active) m_consumed = 0;
    else if (q) m_consumed = 1;
    if (bus.enable) begin
      if (m_state == 0 && q) begin
        if (bus.def_block) begin
          m_health = (m_health - 2 < 1) ? 1 : m_health - 2;
          bp = 1;
        end else begin
          d = (bus.attack_type == 2'd2) ? 20 : 10;
          m_health = (m_health - d < 0) ? 0 : m_health - d;
          hp = 1;
          m_kb = bus.atk_facing_right ? 1 : 0;
          if (m_health == 0) m_state = 3;
          else begin m_state = 1; m_stun = 20; end
        end
      end else if (m_state == 1) begin
        if (m_stun == 1) begin m_state = 2; m_inv = 30; end
        else m_stun--;
      end else if (m_state == 2) begin
        if (m_inv == 1) m_state = 0;
        else m_inv--;
      end
    end
    exp_q.push_back(model_pack(bp, hp));
    last_pulse = hp | bp;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(int ax, int ay, bit fr, bit act, int ty, int dx, int dy, bit blk, bit en);
    bus.atk_pos_x = 10'(ax);  bus.atk_pos_y = 10'(ay);
    bus.atk_facing_right = fr; bus.attack_active = act;
    bus.attack_type = 2'(ty);
    bus.def_pos_x = 10'(dx);  bus.def_pos_y = 10'(dy);
    bus.def_block = blk;      bus.enable = en;
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1; bus.SCEN = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    exp_q.push_back(model_pack(0, 0));
    check(name);
  endtask

  // One frame: SCEN high for one clk, then sample on the following falling edge.
  task automatic do_scen(input string name);
    @(negedge clk);
    if (last_pulse) check_val("pulse_drop", int'(bus.hit_pulse | bus.block_pulse), 0);
    bus.SCEN = 1'b1;
    model_step();
    @(negedge clk);
    bus.SCEN = 1'b0;
    check(name);
  endtask

  // ---------------- test ----------------
  initial begin
    int pulses, stun_frames, inv_frames, blocks;
    bus.SCEN = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_reset();

    //          ax   ay  fr ty  dx   dy  blk en  hit blk kb  hp
    tbl[0]  = '{200, 300, 1, 1, 265, 300, 0, 1,  1, 0, 1,  90};  // right overlap
    tbl[1]  = '{200, 300, 1, 1, 290, 300, 0, 1,  0, 0, 0, 100};  // right edge touch
    tbl[2]  = '{ 10, 300, 0, 2,   0, 300, 0, 1,  1, 0, 0,  80};  // left clamp at 0
    tbl[3]  = '{200, 300, 1, 0, 265, 300, 0, 1,  0, 0, 0, 100};  // type none
    tbl[4]  = '{200, 300, 1, 3, 265, 300, 0, 1,  0, 0, 0, 100};  // type 3
    tbl[5]  = '{200, 300, 1, 1, 265, 360, 0, 1,  0, 0, 0, 100};  // bottom touch
    tbl[6]  = '{200, 300, 1, 1, 265, 241, 0, 1,  1, 0, 1,  90};  // top overlap
    tbl[7]  = '{200, 300, 1, 1, 265, 240, 0, 1,  0, 0, 0, 100};  // top touch
    tbl[8]  = '{200, 300, 1, 1, 201, 300, 0, 1,  1, 0, 1,  90};  // hurtbox right edge just inside
    tbl[9]  = '{200, 300, 1, 1, 200, 300, 0, 1,  0, 0, 0, 100};  // hurtbox right edge touch
    tbl[10] = '{200, 300, 1, 2, 265, 300, 1, 1,  0, 1, 0,  98};  // blocked heavy
    tbl[11] = '{400, 100, 0, 1, 341, 100, 0, 1,  1, 0, 0,  90};  // left overlap
    tbl[12] = '{400, 100, 0, 1, 400, 100, 0, 1,  0, 0, 0, 100};  // left edge touch
    tbl[13] = '{200, 300, 1, 1, 265, 300, 0, 0,  0, 0, 0, 100};  // round disabled
    tbl[14] = '{200, 300, 1, 2, 319, 300, 0, 1,  1, 0, 1,  80};  // heavy reach inside
    tbl[15] = '{200, 300, 1, 2, 320, 300, 0, 1,  0, 0, 0, 100};  // heavy reach touch

    do_reset("reset_state");

    // Table: each vector from reset, one SCEN with attack active.
    for (int i = 0; i < 16; i++) begin
      do_reset("vec_reset");
      set_inputs(tbl[i].ax, tbl[i].ay, tbl[i].fr, 1, tbl[i].ty, tbl[i].dx, tbl[i].dy,
                 tbl[i].blk, tbl[i].en);
      @(negedge clk);
      bus.SCEN = 1'b1;
      exp_q.push_back(pack_exp(tbl[i].e_hp == 0, 0, tbl[i].e_hit, tbl[i].e_blk, tbl[i].e_hit,
                               tbl[i].e_kb, tbl[i].e_hp));
      @(negedge clk);
      bus.SCEN = 1'b0;
      check($sformatf("vec%0d", i));
    end

    // Held attack: one hit, 20 stun frames, 30 invuln frames, new attacks ignored meanwhile.
    do_reset("seq_a_reset");
    set_inputs(200, 300, 1, 1, 1, 265, 300, 0, 1);
    pulses = 0; stun_frames = 0; inv_frames = 0;
    for (int i = 0; i < 5; i++) begin
      do_scen("hold");
      pulses += int'(bus.hit_pulse); stun_frames += int'(bus.hit_stun); inv_frames += int'(bus.invuln);
    end
    for (int i = 0; i < 60; i++) begin
      bus.attack_active = (i < 45) && (i % 4 != 0);
      do_scen("recover");
      pulses += int'(bus.hit_pulse); stun_frames += int'(bus.hit_stun); inv_frames += int'(bus.invuln);
    end
    check_val("hold_pulses", pulses, 1);
    check_val("stun_frames", stun_frames, 20);
    check_val("invuln_frames", inv_frames, 30);
    check_val("back_alive", int'(bus.dbg.state), int'(ST_ALIVE));
    check_val("hold_health", int'(bus.health), 90);

    // Blocked heavies: chip damage floors at 1, never stuns or KOs.
    do_reset("seq_b_reset");
    set_inputs(200, 300, 1, 1, 2, 265, 300, 1, 1);
    blocks = 0;
    for (int i = 0; i < 55; i++) begin
      bus.attack_active = 1'b1;
      do_scen("block_hit");
      blocks += int'(bus.block_pulse);
      bus.attack_active = 1'b0;
      do_scen("block_gap");
    end
    check_val("block_pulses", blocks, 55);
    check_val("block_floor", int'(bus.health), 1);
    check_val("block_no_ko", int'(bus.ko), 0);

    // Five unblocked heavies reach KO; KO then ignores everything until reset.
    do_reset("seq_c_reset");
    set_inputs(200, 300, 1, 0, 2, 265, 300, 0, 1);
    for (int h = 0; h < 5; h++) begin
      bus.attack_active = 1'b1;
      do_scen("ko_hit");
      bus.attack_active = 1'b0;
      if (h < 4) for (int k = 0; k < 50; k++) do_scen("ko_recover");
    end
    check_val("ko_flag", int'(bus.ko), 1);
    check_val("ko_state", int'(bus.dbg.state), int'(ST_KO));
    for (int k = 0; k < 6; k++) begin
      bus.attack_active = (k % 2 == 0);
      bus.attack_type = 2'($urandom_range(1, 2));
      do_scen("ko_ignore");
    end
    do_reset("ko_reset");
    check_val("ko_reset_health", int'(bus.health), 100);

    // Freeze while disabled mid-stun, then reset coinciding with SCEN.
    do_reset("seq_e_reset");
    set_inputs(200, 300, 1, 1, 1, 265, 300, 0, 1);
    do_scen("e_hit");
    bus.attack_active = 1'b0;
    for (int k = 0; k < 3; k++) do_scen("e_stun");
    bus.enable = 1'b0;
    bus.attack_active = 1'b1;
    for (int k = 0; k < 4; k++) do_scen("e_frozen");
    check_val("frozen_cnt", int'(bus.dbg.stun_cnt), 17);
    bus.enable = 1'b1;
    for (int k = 0; k < 2; k++) do_scen("e_resume");
    @(negedge clk);
    bus.SCEN = 1'b1; reset = 1'b1;
    @(negedge clk);
    bus.SCEN = 1'b0; reset = 1'b0;
    model_reset();
    exp_q.push_back(model_pack(0, 0));
    check("reset_with_scen");

    check_val("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Watchdog: the sequence above is a fixed number of clocks.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
